// File: rtl/rr_req_agent.sv
// rr_req_agent
//   Requester-side front end for a round-robin arbiter. Each of NUM_REQ
//   channels buffers transactions in a DEPTH-entry FIFO and raises req while it
//   holds data and the output register can take a new entry. The one-hot gnt
//   returned by the arbiter pops the granted FIFO into a registered
//   valid/ready output. A per-channel counter flags channels that have waited
//   STARVE_LIMIT cycles.
//
//   Optional macro RR_REQ_GNT_CHECK_EN: when defined, a grant that is not
//   one-hot or not a subset of req is rejected and latched into a sticky
//   gnt_err. When undefined, gnt is masked with req, the lowest set bit wins,
//   and gnt_err is tied 0.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   per-channel push handshake
//     in_data             channel i payload at [i*DATA_W +: DATA_W]
//     req / gnt           request vector to arbiter, one-hot grant back
//     out_valid/out_ready registered output handshake
//     out_data, out_src   granted payload and its channel index
//     starve              per-channel starvation flag
//     gnt_err             sticky illegal-grant flag

// Per-channel FIFO plus starvation counter.
module rr_req_chan #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              can_load,
    input  logic [DATA_W-1:0] push_data,
    output logic              not_empty,
    output logic              not_full,
    output logic [DATA_W-1:0] head_data,
    output logic              starve
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [SW-1:0]     wait_cnt;

    assign not_empty = (count != '0);
    assign not_full  = (count < CNT_W'(DEPTH));
    assign head_data = mem[rd_ptr];
    assign starve    = (wait_cnt == SW'(STARVE_LIMIT));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // While not empty and can_load, req is asserted, so an ungranted cycle
    // is exactly a non-pop cycle here.
    always_ff @(posedge clk) begin
        if (rst)                            wait_cnt <= '0;
        else if (pop || !not_empty)         wait_cnt <= '0;
        else if (!can_load)                 wait_cnt <= wait_cnt;
        else if (wait_cnt != SW'(STARVE_LIMIT)) wait_cnt <= wait_cnt + SW'(1);
    end
endmodule

module rr_req_agent #(
    parameter int NUM_REQ      = 10,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         in_valid,
    output logic [NUM_REQ-1:0]         in_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  in_data,
    output logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         gnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    output logic [NUM_REQ-1:0]         starve,
    output logic                       gnt_err
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic                            can_load;
    logic [NUM_REQ-1:0]              not_empty, not_full, push, grant_vec;
    logic [NUM_REQ-1:0][DATA_W-1:0]  head_data;
    logic [DATA_W-1:0]               sel_data;
    logic [SRC_W-1:0]                sel_src;

    assign can_load = !out_valid || out_ready;
    assign in_ready = rst ? '0 : not_full;
    assign req      = (rst || !can_load) ? '0 : not_empty;
    assign push     = in_valid & in_ready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        rr_req_chan #(
            .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .push     (push[i]),
            .pop      (grant_vec[i]),
            .can_load (can_load),
            .push_data(in_data[i*DATA_W +: DATA_W]),
            .not_empty(not_empty[i]),
            .not_full (not_full[i]),
            .head_data(head_data[i]),
            .starve   (starve[i])
        );
    end

`ifdef RR_REQ_GNT_CHECK_EN
    logic gnt_legal;
    assign gnt_legal = $onehot0(gnt) && ((gnt & ~req) == '0);
    // An illegal grant pops nothing and loads nothing.
    assign grant_vec = gnt_legal ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst)             gnt_err <= 1'b0;
        else if (!gnt_legal) gnt_err <= 1'b1;
    end

    a_gnt_legal: assert property (@(posedge clk) disable iff (rst) gnt_legal);
`else
    logic [NUM_REQ-1:0] gnt_m;
    assign gnt_m     = gnt & req;
    assign grant_vec = gnt_m & (~gnt_m + NUM_REQ'(1));
    assign gnt_err   = 1'b0;
`endif

    // grant_vec is one-hot or zero, so OR-reduction is a clean mux.
    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i]) begin
                sel_data = sel_data | head_data[i];
                sel_src  = sel_src | SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (grant_vec != '0) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= sel_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_req_agent.sv
module tb_rr_req_agent;
    localparam int N  = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid, in_ready, req, gnt, starve, gnt_force, r_mask;
    logic [N*DW-1:0] in_data;
    logic          out_valid, out_ready, gnt_err;
    logic [DW-1:0] out_data;
    logic [3:0]    out_src;
    int            mode;
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    rr_req_agent #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(2), .STARVE_LIMIT(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .req(req), .gnt(gnt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .starve(starve), .gnt_err(gnt_err)
    );

    // Arbiter model: 0 = lowest req bit, 1 = lowest excluding ch0, 2 = forced.
    always_comb begin
        r_mask = (mode == 1) ? (req & ~10'h001) : req;
        gnt    = (mode == 2) ? gnt_force : (r_mask & (~r_mask + 10'd1));
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] iv;
        logic [7:0]   d;
        logic         ordy;
        logic [N-1:0] e_ir;
        logic [N-1:0] e_req;
        logic         e_ov;
        logic [7:0]   e_d;
        logic [3:0]   e_src;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] d);
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {24'h0, d};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = '0; out_ready = 1'b1; mode = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; out_ready = 1'b1; mode = 0;
        gnt_force = '0; set_data(8'h00);

        //         rst iv       d      rdy ir       req      ov  d      src
        vecs[0]  = '{1'b1, 10'h3FF, 8'h00, 1'b1, 10'h000, 10'h000, 1'b0, 8'h00, 4'd0};
        vecs[1]  = '{1'b1, 10'h3FF, 8'h00, 1'b1, 10'h000, 10'h000, 1'b0, 8'h00, 4'd0};
        vecs[2]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h000, 1'b0, 8'h00, 4'd0};
        vecs[3]  = '{1'b0, 10'h008, 8'hA5, 1'b1, 10'h3FF, 10'h000, 1'b0, 8'h00, 4'd0};
        vecs[4]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h008, 1'b0, 8'h00, 4'd0};
        vecs[5]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h000, 1'b1, 8'hA5, 4'd3};
        vecs[6]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h000, 1'b0, 8'h00, 4'd0};
        vecs[7]  = '{1'b0, 10'h0A0, 8'h33, 1'b1, 10'h3FF, 10'h000, 1'b0, 8'h00, 4'd0};
        vecs[8]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h0A0, 1'b0, 8'h00, 4'd0};
        vecs[9]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h080, 1'b1, 8'h33, 4'd5};
        vecs[10] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h000, 1'b1, 8'h33, 4'd7};
        vecs[11] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h000, 1'b0, 8'h00, 4'd0};
        // Backpressure on ch9: fill while output is blocked, then drain.
        vecs[12] = '{1'b0, 10'h200, 8'h44, 1'b0, 10'h3FF, 10'h000, 1'b0, 8'h00, 4'd0};
        vecs[13] = '{1'b0, 10'h200, 8'h45, 1'b0, 10'h3FF, 10'h200, 1'b0, 8'h00, 4'd0};
        vecs[14] = '{1'b0, 10'h200, 8'h46, 1'b0, 10'h3FF, 10'h000, 1'b1, 8'h44, 4'd9};
        vecs[15] = '{1'b0, 10'h200, 8'h47, 1'b0, 10'h1FF, 10'h000, 1'b1, 8'h44, 4'd9};
        vecs[16] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h1FF, 10'h200, 1'b1, 8'h44, 4'd9};
        vecs[17] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h200, 1'b1, 8'h45, 4'd9};
        vecs[18] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h000, 1'b1, 8'h46, 4'd9};
        vecs[19] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF, 10'h000, 1'b0, 8'h00, 4'd0};

        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
            set_data(vecs[i].d);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d req", i), 32'(req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov || vecs[i].rst) begin
                chk($sformatf("v%0d out_data", i), out_data, {24'h0, vecs[i].e_d});
                chk($sformatf("v%0d out_src", i), 32'(out_src), 32'(vecs[i].e_src));
            end
            chk($sformatf("v%0d starve", i), 32'(starve), 32'h0);
            chk($sformatf("v%0d gnt_err", i), 32'(gnt_err), 32'h0);
        end

        // FIFO wrap: 0x10..0x16 through ch1 with irregular downstream ready.
        begin
            logic [7:0] pat;
            int pushed, rcv;
            pat = 8'b1011_0110; pushed = 0; rcv = 0;
            do_reset();
            for (int cyc = 0; cyc < 100 && rcv < 7; cyc++) begin
                @(negedge clk);
                in_valid  = (pushed < 7) ? 10'h002 : 10'h000;
                set_data(8'(8'h10 + pushed));
                out_ready = pat[cyc % 8];
                #1;
                if (in_valid[1] && in_ready[1]) pushed++;
                if (out_valid && out_ready) begin
                    chk($sformatf("wrap data %0d", rcv), out_data, 32'(8'h10 + rcv));
                    chk($sformatf("wrap src %0d", rcv), 32'(out_src), 32'd1);
                    rcv++;
                end
            end
            chk("wrap count", 32'(rcv), 32'd7);
            @(negedge clk);
            in_valid = '0; out_ready = 1'b1;
            #1;
            chk("wrap no extra", 32'(out_valid), 32'd0);
        end

        // Starvation on ch0: arbiter skips ch0 for 64 cycles, then grants it.
        do_reset();
        mode = 1;
        @(negedge clk);
        in_valid = 10'h001; set_data(8'hC0);
        @(negedge clk);
        in_valid = '0;
        for (int j = 0; j <= 64; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            if (j == 63) chk("starve before limit", 32'(starve), 32'h0);
            if (j == 64) begin
                chk("starve at limit", 32'(starve), 32'h001);
                chk("starve req", 32'(req), 32'h001);
                mode = 0;
            end
        end
        @(negedge clk);
        #1;
        chk("starve cleared", 32'(starve), 32'h0);
        chk("starve out_valid", 32'(out_valid), 32'd1);
        chk("starve out_data", out_data, 32'hC0);
        chk("starve out_src", 32'(out_src), 32'd0);

        // Two-hot grant against req=0x006.
        do_reset();
        @(negedge clk);
        in_valid = 10'h006; set_data(8'h91);
        @(negedge clk);
        in_valid = '0; mode = 2; gnt_force = 10'h006;
        #1;
        chk("illegal req", 32'(req), 32'h006);
        @(negedge clk);
        mode = 0;
        #1;
`ifdef RR_REQ_GNT_CHECK_EN
        chk("illegal no load", 32'(out_valid), 32'd0);
        chk("illegal req kept", 32'(req), 32'h006);
        chk("gnt_err set", 32'(gnt_err), 32'd1);
        @(negedge clk);
        #1;
        chk("gnt_err sticky", 32'(gnt_err), 32'd1);
        chk("post-illegal src", 32'(out_src), 32'd1);
        do_reset();
        #1;
        chk("gnt_err cleared", 32'(gnt_err), 32'd0);
`else
        chk("masked out_valid", 32'(out_valid), 32'd1);
        chk("masked out_src", 32'(out_src), 32'd1);
        chk("masked out_data", out_data, 32'h91);
        chk("masked req", 32'(req), 32'h004);
        chk("masked gnt_err", 32'(gnt_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
